// File: rtl/wb_pkg.sv
// Shared definitions for the write-back buffer: widths, default depth and the entry record.
package wb_pkg;

   localparam int XLEN          = 32;
   localparam int REG_ADDR_W    = 5;
   localparam int DEPTH_DEFAULT = 4;
   localparam int COUNT_W       = 4;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of pending register writes; exposes every slot's rd and occupancy for hazard checks.
module wb_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic [4:0]                           push_rd,
   input  logic [DATA_W-1:0]                    push_data,
   input  logic                                 pop,
   output logic [4:0]                           head_rd,
   output logic [DATA_W-1:0]                    head_data,
   output logic [3:0]                           count,
   output logic [DEPTH-1:0][4:0]                entry_rd,
   output logic [DEPTH-1:0]                     entry_valid
);
   import wb_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]                   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]                   wr_ptr_q, wr_ptr_d;
   logic [COUNT_W-1:0]                 count_q, count_d;
   logic [DEPTH-1:0][REG_ADDR_W-1:0]   rd_mem_q, rd_mem_d;
   logic [DEPTH-1:0][DATA_W-1:0]       data_mem_q, data_mem_d;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      if (push) begin
         rd_mem_d[wr_ptr_q]   = push_rd;
         data_mem_d[wr_ptr_q] = push_data;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + COUNT_W'(1);
         2'b01:   count_d = count_q - COUNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clock) begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
   end

   // A slot is live when its distance from the read pointer is below the occupancy count.
   always_comb begin
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_valid[i] = COUNT_W'(PTR_W'(PTR_W'(i) - rd_ptr_q)) < count_q;
      end
   end

   assign entry_rd  = rd_mem_q;
   assign head_rd   = rd_mem_q[rd_ptr_q];
   assign head_data = data_mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU/load results into a small FIFO that drains into the register file.
module writeback_unit #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            wb_stall,
   output logic            load,
   output logic [4:0]      w_address,
   output logic [XLEN-1:0] w_in,
   input  logic [4:0]      r1_address,
   input  logic [4:0]      r2_address,
   output logic            r1_busy,
   output logic            r2_busy,
   output logic [3:0]      count
);
   import wb_pkg::*;

   logic                    has_space;
   logic                    push;
   logic [REG_ADDR_W-1:0]   push_rd;
   logic [XLEN-1:0]         push_data;
   logic [REG_ADDR_W-1:0]   head_rd;
   logic [XLEN-1:0]         head_data;
   logic [DEPTH-1:0][4:0]   entry_rd;
   logic [DEPTH-1:0]        entry_valid;
   logic                    not_empty;

   // Loads win over ALU results; writes to x0 handshake but are dropped.
   always_comb begin
      has_space = count < COUNT_W'(DEPTH);
      mem_ready = has_space;
      alu_ready = has_space && !mem_valid;
      push      = 1'b0;
      push_rd   = '0;
      push_data = '0;
      if (mem_valid && mem_ready) begin
         push      = mem_rd != '0;
         push_rd   = mem_rd;
         push_data = mem_data;
      end else if (alu_valid && alu_ready) begin
         push      = alu_rd != '0;
         push_rd   = alu_rd;
         push_data = alu_data;
      end
   end

   wb_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (XLEN)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push        (push),
      .push_rd     (push_rd),
      .push_data   (push_data),
      .pop         (load),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .count       (count),
      .entry_rd    (entry_rd),
      .entry_valid (entry_valid)
   );

   always_comb begin
      not_empty = count != '0;
      load      = not_empty && !wb_stall;
      w_address = not_empty ? head_rd : '0;
      w_in      = not_empty ? head_data : '0;
   end

   always_comb begin
      r1_busy = 1'b0;
      r2_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && entry_rd[i] == r1_address) r1_busy = 1'b1;
         if (entry_valid[i] && entry_rd[i] == r2_address) r2_busy = 1'b1;
      end
      if (r1_address == '0) r1_busy = 1'b0;
      if (r2_address == '0) r2_busy = 1'b0;
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized checks of writeback_unit against a queue-based reference model.
module tb_writeback_unit;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid, mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        wb_stall;
   logic        load;
   logic [4:0]  w_address;
   logic [31:0] w_in;
   logic [4:0]  r1_address, r2_address;
   logic        r1_busy, r2_busy;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;

   wb_entry_t model_q[$];

   always #5 clock = ~clock;

   writeback_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clock      (clock),
      .reset      (reset),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .wb_stall   (wb_stall),
      .load       (load),
      .w_address  (w_address),
      .w_in       (w_in),
      .r1_address (r1_address),
      .r2_address (r2_address),
      .r1_busy    (r1_busy),
      .r2_busy    (r2_busy),
      .count      (count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_busy(input logic [4:0] addr);
      if (addr == 5'd0) return 1'b0;
      foreach (model_q[i]) if (model_q[i].rd == addr) return 1'b1;
      return 1'b0;
   endfunction

   task automatic apply_stimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                 input logic st, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic rst);
      alu_valid  = av;
      alu_rd     = ard;
      alu_data   = ad;
      mem_valid  = mv;
      mem_rd     = mrd;
      mem_data   = md;
      wb_stall   = st;
      r1_address = r1;
      r2_address = r2;
      reset      = rst;
      #1;
   endtask

   task automatic idle(input logic st, input logic [4:0] r1);
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st, r1, 5'd0, 1'b0);
   endtask

   task automatic check_output();
      bit space;
      bit nonempty;
      space    = model_q.size() < DEPTH;
      nonempty = model_q.size() != 0;
      check("mem_ready", 64'(mem_ready), 64'(space));
      check("alu_ready", 64'(alu_ready), 64'(space && !mem_valid));
      check("load",      64'(load),      64'(nonempty && !wb_stall));
      check("w_address", 64'(w_address), nonempty ? 64'(model_q[0].rd) : 64'd0);
      check("w_in",      64'(w_in),      nonempty ? 64'(model_q[0].data) : 64'd0);
      check("r1_busy",   64'(r1_busy),   64'(model_busy(r1_address)));
      check("r2_busy",   64'(r2_busy),   64'(model_busy(r2_address)));
      check("count",     64'(count),     64'(model_q.size()));
   endtask

   // Advance one clock and apply the acceptance/drain rules to the model.
   task automatic tick();
      bit        space, do_pop, do_push;
      wb_entry_t e;
      space   = model_q.size() < DEPTH;
      do_pop  = model_q.size() != 0 && !wb_stall;
      do_push = 1'b0;
      e       = '0;
      if (mem_valid && space) begin
         do_push = mem_rd != 5'd0;
         e.rd    = mem_rd;
         e.data  = mem_data;
      end else if (alu_valid && space) begin
         do_push = alu_rd != 5'd0;
         e.rd    = alu_rd;
         e.data  = alu_data;
      end
      @(posedge clock);
      if (reset) begin
         model_q.delete();
      end else begin
         if (do_pop) void'(model_q.pop_front());
         if (do_push) model_q.push_back(e);
      end
      #1;
   endtask

   initial begin
      apply_stimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b1);
      tick();
      tick();

      idle(1'b0, 5'd0);
      check("reset_count", 64'(count), 64'd0);
      check("reset_load", 64'(load), 64'd0);
      check("reset_alu_ready", 64'(alu_ready), 64'd1);
      check("reset_mem_ready", 64'(mem_ready), 64'd1);
      check_output();

      // Single ALU result into an empty buffer.
      apply_stimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0, 1'b0);
      check_output();
      tick();
      idle(1'b0, 5'd5);
      check("alu5_load", 64'(load), 64'd1);
      check("alu5_addr", 64'(w_address), 64'd5);
      check("alu5_data", 64'(w_in), 64'h1234_5678);
      check("alu5_busy", 64'(r1_busy), 64'd1);
      check_output();
      tick();
      check("alu5_drained", 64'(count), 64'd0);
      check_output();

      // Simultaneous offers: load result first, ALU waits one cycle.
      apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 5'd3, 5'd4, 1'b0);
      check("arb_alu_ready", 64'(alu_ready), 64'd0);
      check("arb_mem_ready", 64'(mem_ready), 64'd1);
      check_output();
      tick();
      apply_stimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4, 1'b0);
      check("arb_alu_ready2", 64'(alu_ready), 64'd1);
      check("arb_first_write", 64'(w_address), 64'd4);
      check_output();
      tick();
      idle(1'b0, 5'd3);
      check("arb_second_write", 64'(w_address), 64'd3);
      check_output();
      tick();
      check_output();

      // Stall until full, then drain in order across the pointer wrap.
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 5'(10 + i), 32'(100 + i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 1'b0);
         check_output();
         tick();
      end
      apply_stimulus(1'b1, 5'd20, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 1'b0);
      check("full_count", 64'(count), 64'd4);
      check("full_alu_ready", 64'(alu_ready), 64'd0);
      check("full_mem_ready", 64'(mem_ready), 64'd0);
      check("full_load", 64'(load), 64'd0);
      check_output();
      tick();
      for (int i = 0; i < 4; i++) begin
         idle(1'b0, 5'd12);
         check("drain_load", 64'(load), 64'd1);
         check("drain_addr", 64'(w_address), 64'(10 + i));
         check("drain_data", 64'(w_in), 64'(100 + i));
         check_output();
         tick();
      end
      check("drain_empty", 64'(count), 64'd0);

      // Writes to x0 are accepted but dropped.
      apply_stimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 1'b0);
      check("x0_alu_ready", 64'(alu_ready), 64'd1);
      check_output();
      tick();
      idle(1'b0, 5'd0);
      check("x0_count", 64'(count), 64'd0);
      check("x0_load", 64'(load), 64'd0);
      check("x0_busy", 64'(r1_busy), 64'd0);
      check_output();
      tick();

      // Two writes to the same register stay ordered; busy holds until the last one.
      apply_stimulus(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0, 1'b0);
      check_output();
      tick();
      apply_stimulus(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd0, 1'b0);
      check("waw_first", 64'(w_in), 64'hA);
      check("waw_busy1", 64'(r1_busy), 64'd1);
      check_output();
      tick();
      idle(1'b0, 5'd7);
      check("waw_second", 64'(w_in), 64'hB);
      check("waw_busy2", 64'(r1_busy), 64'd1);
      check_output();
      tick();
      check("waw_busy_clear", 64'(r1_busy), 64'd0);
      check_output();

      // Reset with three entries pending discards them.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 5'(20 + i), 32'(200 + i), 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 5'd0, 1'b0);
         check_output();
         tick();
      end
      check("pre_reset_count", 64'(count), 64'd3);
      apply_stimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd21, 5'd0, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(1'b0, 5'd21);
         check("post_reset_count", 64'(count), 64'd0);
         check("post_reset_load", 64'(load), 64'd0);
         check_output();
         tick();
      end

      // Randomized traffic with stalls and occasional resets.
      for (int n = 0; n < 400; n++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                        1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)), $urandom,
                        1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
                        5'($urandom_range(0, 15)), 1'($urandom_range(0, 49) == 0));
         check_output();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DEPTH, default 4, means the number of buffered write-back entries (power of two, 2..8).
REQ-002 Parameter XLEN, default 32, means the data width of one register.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 alu_valid  in  1  ALU result offered.
REQ-006 alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
REQ-007 alu_rd  in  5  ALU destination register.
REQ-008 alu_data  in  XLEN  ALU result.
REQ-009 mem_valid  in  1  load result offered.
REQ-010 mem_ready  out  1  load result accepted this cycle when mem_valid is also high.
REQ-011 mem_rd  in  5  load destination register.
REQ-012 mem_data  in  XLEN  load result.
REQ-013 wb_stall  in  1  register-file write port unavailable this cycle.
REQ-014 load  out  1  register-file write enable.
REQ-015 w_address  out  5  register-file write address.
REQ-016 w_in  out  XLEN  register-file write data.
REQ-017 r1_address, r2_address  in  5 each  decode-stage source registers.
REQ-018 r1_busy, r2_busy  out  1 each  the matching source register has a pending write.
REQ-019 count  out  4  number of occupied entries.

Function
REQ-020 A transfer occurs on a source when its valid and ready are both high at a rising edge.
REQ-021 mem_ready SHALL equal (count < DEPTH); alu_ready SHALL equal (count < DEPTH) AND NOT mem_valid (load results have fixed priority).
REQ-022 At most one entry SHALL be enqueued per cycle; ready SHALL NOT depend on a same-cycle pop (no full-bypass).
REQ-023 A transfer with rd = 0 SHALL complete the handshake but SHALL NOT enqueue, and count SHALL be unchanged.
REQ-024 load SHALL equal (count != 0) AND NOT wb_stall, combinationally.
REQ-025 w_address and w_in SHALL show the head entry when count != 0, and SHALL be 0 when the FIFO is empty.
REQ-026 The head SHALL be popped at every edge where load is high.
REQ-027 Latency: an entry accepted at edge k into an empty FIFO with wb_stall low SHALL drive load high during cycle k..k+1 and is written at edge k+1.
REQ-028 Entries SHALL drain in acceptance order, so the last write to any register wins.
REQ-029 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-030 Pointers SHALL wrap modulo DEPTH.
REQ-031 rN_busy SHALL be high iff rN_address != 0 and any occupied entry, head included, has rd == rN_address; this is combinational.
REQ-032 A push of a new entry SHALL raise the matching busy signal from the following cycle.
REQ-033 While wb_stall is high, no pop SHALL occur, and the FIFO may fill to DEPTH, forcing both readies low.

Reset
REQ-034 When reset is high at an edge, count, read and write pointers SHALL go to 0; load, w_address, w_in, r1_busy and r2_busy are therefore 0 in the next cycle.
REQ-035 Reset mid-operation SHALL discard all pending entries without any register-file write.
REQ-036 Readies SHALL be high in the cycle after reset, and inputs presented during reset SHALL NOT be enqueued.

Structure
REQ-037 Shared package wb_pkg SHALL hold XLEN, REG_ADDR_W=5, the DEPTH default, and the entry record {rd[4:0], data[XLEN-1:0]}.
REQ-038 The storage SHALL be one sub-module wb_fifo (push, pop, count, per-entry rd/valid visibility for the hazard compare).
REQ-039 Arbitration, x0 filtering and busy compares SHALL live in writeback_unit.

Verification
REQ-040 The bench SHALL cover: ALU push rd=5, data=0x1234_5678, into an empty FIFO -> next cycle load=1, w_address=5, w_in=0x12345678, r1_busy=1 with r1_address=5, then count returns to 0.
REQ-041 The bench SHALL cover: alu_valid and mem_valid both high (rd 3 / rd 4) -> mem accepted and alu_ready=0; ALU accepted the next cycle; writes occur to 4 then 3.
REQ-042 The bench SHALL cover: wb_stall=1 and 4 pushes -> count=4, both readies 0, load=0; release stall -> 4 consecutive writes in order, pointers wrap.
REQ-043 The bench SHALL cover: push rd=0 with data 0xFFFF_FFFF -> handshake completes, count stays 0, load stays 0, r1_busy=0 with r1_address=0.
REQ-044 The bench SHALL cover: two pushes to rd=7 (0xA, then 0xB) -> writes 0xA then 0xB, and r1_busy stays high until the second write pops.
REQ-045 The bench SHALL cover: reset asserted with count=3 -> next cycle count=0, load=0, and no further writes.
